atm_session_ctrl: RTL and testbench
===================================

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter N_TRIES, default 3: PIN attempts per card insertion (1..3).
REQ-003 SHALL have parameter TIMEOUT, default 1000: idle cycles allowed in WAIT/SESSION (>=2).
REQ-004 SHALL have parameter LOCK_DEPTH, default 4: locked-card table entries.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- card_in  in  1  one-cycle pulse, card inserted, card_no valid
- card_no  in  10  card number
- auth_req  out  1  one-cycle pulse to authenticator
- auth_done  in  1  authenticator result-valid pulse
- auth_ok  in  1  authenticator flag, sampled only with auth_done
- key_act  in  1  keypad activity, restarts idle timer
- txn_done  in  1  pulse, user finished
- cancel  in  1  user cancel
- session_active  out  1  high in SESSION
- attempts_left  out  2  remaining PIN tries
- card_locked  out  1  high in EJECT when the cause is lockout
- eject  out  1  one-cycle card-eject pulse
- state  out  3  IDLE=0, REQ=1, WAIT=2, SESSION=3, EJECT=4

Function
REQ-006 All outputs SHALL be registered or decoded from state only (Moore).
REQ-007 IDLE: card_in with card_no matching a valid lock-table entry -> EJECT with card_locked set; otherwise latch card_no, attempts_left=N_TRIES, -> REQ.
REQ-008 card_in SHALL be ignored outside IDLE.
REQ-009 REQ: auth_req=1 for exactly this one cycle; -> WAIT; idle timer cleared.
REQ-010 WAIT, priority high to low: cancel -> EJECT; auth_done&auth_ok -> SESSION; auth_done&!auth_ok -> decrement attempts_left; timer==TIMEOUT-1 -> EJECT.
REQ-011 On failed auth: if the new attempts_left>0 -> REQ (re-request); if 0 -> write latched card into lock table, -> EJECT with card_locked set.
REQ-012 SESSION: session_active=1; cancel or txn_done -> EJECT; key_act clears timer; timer==TIMEOUT-1 with no key_act -> EJECT.
REQ-013 The timer SHALL clear on entry to WAIT and SESSION and increment once per cycle in those states. Eject therefore occurs TIMEOUT cycles after entry when there are no events.
REQ-014 EJECT: eject=1 for one cycle; card_locked=1 in that same cycle only for lock causes; -> IDLE; attempts_left cleared to 0.
REQ-015 Lock table: LOCK_DEPTH entries with per-entry valid bits; writes go to a write pointer that wraps modulo LOCK_DEPTH, overwriting the oldest entry.
REQ-016 The lock-table match SHALL compare all 10 bits, valid entries only, and be combinational on card_no in IDLE.
REQ-017 The timer width SHALL hold TIMEOUT-1 without overflow. attempts_left SHALL never underflow below 0.
REQ-018 Unused state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE and all outputs to 0, clear timer, attempts_left, and the latched card. It SHALL clear all lock-table valid bits and reset the write pointer to 0.
REQ-020 Reset asserted mid-WAIT or mid-SESSION SHALL NOT produce an eject pulse. Operation SHALL resume on the first clock after rst_n rises.

Verification
REQ-021 Bench SHALL cover card_in with card_no=37 and auth_ok=1 on the first try -> auth_req 1 cycle after card_in, attempts_left=3, session_active. Then txn_done -> eject 1 cycle, state 0.
REQ-022 Bench SHALL cover card 37 with 3 failed auth_done -> attempts_left 2,1,0 and auth_req 3 times, then card_locked+eject. Reinserting 37 -> eject+card_locked with no auth_req.
REQ-023 Bench SHALL cover locking cards 1..5 with LOCK_DEPTH=4 -> card 1 authenticates normally, and cards 2..5 eject locked.
REQ-024 Bench SHALL cover TIMEOUT=10 with no auth_done -> eject 10 cycles after entering WAIT. In SESSION, key_act every 8 cycles -> no eject for 50 cycles.
REQ-025 Bench SHALL cover cancel and auth_done&auth_ok in the same WAIT cycle -> EJECT, session_active never high, attempts_left unchanged until EJECT.
REQ-026 Bench SHALL cover rst_n low for 1 cycle mid-SESSION after card 37 was locked -> outputs 0 at once, no eject pulse, and card 37 is no longer locked.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ATM card session controller: PIN retry handling, idle timeouts and a small
// locked-card table consulted on card insertion. All outputs are Moore.
module atm_session_ctrl #(
    parameter int N_TRIES    = 3,
    parameter int TIMEOUT    = 1000,
    parameter int LOCK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       card_in,
    input  logic [9:0] card_no,
    output logic       auth_req,
    input  logic       auth_done,
    input  logic       auth_ok,
    input  logic       key_act,
    input  logic       txn_done,
    input  logic       cancel,
    output logic       session_active,
    output logic [1:0] attempts_left,
    output logic       card_locked,
    output logic       eject,
    output logic [2:0] state
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int PW = (LOCK_DEPTH > 1) ? $clog2(LOCK_DEPTH) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
    localparam logic [1:0]    TRIES = 2'(N_TRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_SESSION = 3'd3,
        S_EJECT   = 3'd4
    } state_t;

    state_t          cur, nxt;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      att_q, att_d;
    logic [9:0]      card_q, card_d;
    logic            cause_q, cause_d;
    logic            lk_wr, hit;
    logic [9:0]      tbl [LOCK_DEPTH];
    logic [LOCK_DEPTH-1:0] vld;
    logic [PW-1:0]   wr_ptr;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOCK_DEPTH; i++)
            if (vld[i] && tbl[i] == card_no) hit = 1'b1;
    end

    always_comb begin
        nxt     = cur;
        timer_d = '0;
        att_d   = att_q;
        card_d  = card_q;
        cause_d = cause_q;
        lk_wr   = 1'b0;
        case (cur)
            S_IDLE: begin
                if (card_in) begin
                    if (hit) begin
                        nxt     = S_EJECT;
                        cause_d = 1'b1;
                    end else begin
                        nxt     = S_REQ;
                        card_d  = card_no;
                        att_d   = TRIES;
                        cause_d = 1'b0;
                    end
                end
            end
            S_REQ: nxt = S_WAIT;
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (cancel) begin
                    nxt = S_EJECT;
                end else if (auth_done && auth_ok) begin
                    nxt     = S_SESSION;
                    timer_d = '0;
                end else if (auth_done) begin
                    att_d = (att_q != 2'd0) ? att_q - 1'b1 : 2'd0;
                    // last try failed: remember the card before ejecting it
                    if (att_q > 2'd1) begin
                        nxt = S_REQ;
                    end else begin
                        nxt     = S_EJECT;
                        lk_wr   = 1'b1;
                        cause_d = 1'b1;
                    end
                end else if (timer_q == TMAX) begin
                    nxt = S_EJECT;
                end
            end
            S_SESSION: begin
                timer_d = timer_q + 1'b1;
                if (cancel || txn_done)    nxt = S_EJECT;
                else if (key_act)          timer_d = '0;
                else if (timer_q == TMAX)  nxt = S_EJECT;
            end
            S_EJECT: begin
                nxt     = S_IDLE;
                att_d   = 2'd0;
                cause_d = 1'b0;
            end
            default: begin
                nxt     = S_IDLE;
                att_d   = 2'd0;
                cause_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            timer_q <= '0;
            att_q   <= '0;
            card_q  <= '0;
            cause_q <= 1'b0;
            vld     <= '0;
            wr_ptr  <= '0;
            for (int i = 0; i < LOCK_DEPTH; i++) tbl[i] <= '0;
        end else begin
            cur     <= nxt;
            timer_q <= timer_d;
            att_q   <= att_d;
            card_q  <= card_d;
            cause_q <= cause_d;
            if (lk_wr) begin
                tbl[wr_ptr] <= card_q;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= (wr_ptr == PW'(LOCK_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    assign state          = cur;
    assign auth_req       = (cur == S_REQ);
    assign session_active = (cur == S_SESSION);
    assign eject          = (cur == S_EJECT);
    assign card_locked    = (cur == S_EJECT) && cause_q;
    assign attempts_left  = att_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Randomized bench for atm_session_ctrl: a timed card-session script predicts
// every auth_req / session-start / eject event into a queue, a monitor pops them.
module tb_atm_session_ctrl;
    localparam int NT  = 3;
    localparam int TMO = 10;
    localparam int LD  = 4;

    localparam int EV_AUTH = 0, EV_SESS = 1, EV_EJ = 2;
    localparam int M_TXN = 0, M_TMO = 1, M_CAN = 2, M_CANOK = 3, M_KEEP = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       card_in = 1'b0, auth_done = 1'b0, auth_ok = 1'b0;
    logic       key_act = 1'b0, txn_done = 1'b0, cancel = 1'b0;
    logic [9:0] card_no = '0;
    logic       auth_req, session_active, card_locked, eject;
    logic [1:0] attempts_left;
    logic [2:0] state;

    typedef struct {
        int kind;
        int cyc;
        int att;
        int lck;
    } ev_t;

    ev_t exq[$];
    int  locked_q[$];
    int  cyc = 0;
    int  n_vec = 0, n_err = 0;

    atm_session_ctrl #(.N_TRIES(NT), .TIMEOUT(TMO), .LOCK_DEPTH(LD)) dut (
        .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_no(card_no),
        .auth_req(auth_req), .auth_done(auth_done), .auth_ok(auth_ok),
        .key_act(key_act), .txn_done(txn_done), .cancel(cancel),
        .session_active(session_active), .attempts_left(attempts_left),
        .card_locked(card_locked), .eject(eject), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit is_locked(input int c);
        foreach (locked_q[i]) if (locked_q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic lock_add(input int c);
        if (locked_q.size() == LD) void'(locked_q.pop_front());
        locked_q.push_back(c);
    endtask

    task automatic push(input int kind, input int c, input int att, input int lck);
        ev_t e;
        e.kind = kind; e.cyc = c; e.att = att; e.lck = lck;
        exq.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        card_in   = 1'b0;
        auth_done = 1'b0;
        txn_done  = 1'b0;
        cancel    = 1'b0;
        key_act   = 1'b0;
        auth_ok   = 1'($urandom_range(0, 1));
    endtask

    // idle cycle outside IDLE, with a stray card_in that must be ignored
    task automatic noise_step();
        card_in = 1'($urandom_range(0, 1));
        card_no = 10'($urandom_range(0, 1023));
        step();
    endtask

    task automatic idle_check(input int ej);
        while (cyc < ej + 1) step();
        n_vec++;
        if ({state, attempts_left, eject, auth_req, session_active, card_locked} != 9'd0) begin
            n_err++;
            $display("FAIL after_eject: state=%0d att=%0d ej=%0b req=%0b sa=%0b lck=%0b, want all 0 at cyc %0d",
                     state, attempts_left, eject, auth_req, session_active, card_locked, cyc);
        end
    endtask

    task automatic run_card(input int card, input int nfail, input int mode);
        int att, e, ej, k;
        card_in = 1'b1;
        card_no = 10'(card);
        if (is_locked(card)) begin
            ej = cyc + 1;
            push(EV_EJ, ej, 0, 1);
            step();
            idle_check(ej);
            return;
        end
        att = NT;
        push(EV_AUTH, cyc + 1, att, 0);
        step();
        step();
        e = cyc;
        for (int i = 0; i < nfail; i++) begin
            k = int'($urandom_range(0, 4));
            repeat (k) noise_step();
            auth_done = 1'b1;
            auth_ok   = 1'b0;
            att--;
            if (att > 0) begin
                push(EV_AUTH, cyc + 1, att, 0);
                step();
                step();
                e = cyc;
            end else begin
                lock_add(card);
                ej = cyc + 1;
                push(EV_EJ, ej, 0, 1);
                step();
                idle_check(ej);
                return;
            end
        end
        if (mode == M_TMO) begin
            ej = e + TMO;
            push(EV_EJ, ej, att, 0);
        end else begin
            k = int'($urandom_range(0, 4));
            repeat (k) noise_step();
            if (mode == M_CAN || mode == M_CANOK) begin
                cancel = 1'b1;
                if (mode == M_CANOK) begin
                    auth_done = 1'b1;
                    auth_ok   = 1'b1;
                end
                ej = cyc + 1;
                push(EV_EJ, ej, att, 0);
                step();
            end else begin
                auth_done = 1'b1;
                auth_ok   = 1'b1;
                push(EV_SESS, cyc + 1, att, 0);
                step();
                if (mode == M_KEEP) begin
                    e = cyc;
                    for (int i = 1; i <= 7; i++) begin
                        while (cyc < e + 8 * i - 1) noise_step();
                        key_act = 1'b1;
                        step();
                    end
                    ej = cyc + TMO;
                    push(EV_EJ, ej, att, 0);
                end else begin
                    k = int'($urandom_range(0, 5));
                    repeat (k) noise_step();
                    txn_done = 1'b1;
                    ej = cyc + 1;
                    push(EV_EJ, ej, att, 0);
                    step();
                end
            end
        end
        idle_check(ej);
    endtask

    // ---------------- monitor ----------------
    task automatic check_ev(input int kind);
        ev_t e;
        n_vec++;
        if (exq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind=%0d at cyc %0d att=%0d lck=%0b, want no event",
                     kind, cyc, attempts_left, card_locked);
            return;
        end
        e = exq.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.att != int'(attempts_left) ||
            e.lck != int'(card_locked) || (kind == EV_EJ && state != 3'd4)) begin
            n_err++;
            $display("FAIL event: got kind=%0d cyc=%0d att=%0d lck=%0b st=%0d, want kind=%0d cyc=%0d att=%0d lck=%0d",
                     kind, cyc, attempts_left, card_locked, state, e.kind, e.cyc, e.att, e.lck);
        end
    endtask

    initial begin
        bit sa_q;
        sa_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sa_q = 1'b0;
                if (eject) begin
                    n_vec++; n_err++;
                    $display("FAIL eject_in_reset: eject=1, want 0 at cyc %0d", cyc);
                end
            end else begin
                if (auth_req) check_ev(EV_AUTH);
                if (session_active && !sa_q) check_ev(EV_SESS);
                if (eject) check_ev(EV_EJ);
                sa_q = session_active;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({state, attempts_left, eject, auth_req, session_active, card_locked} != 9'd0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d att=%0d ej=%0b req=%0b sa=%0b lck=%0b, want all 0",
                     state, attempts_left, eject, auth_req, session_active, card_locked);
        end
        rst_n = 1'b1;
        step();

        run_card(37, 0, M_TXN);
        run_card(37, NT, M_TXN);
        run_card(37, 0, M_TXN);

        // reset for one cycle in the middle of a session
        card_in = 1'b1;
        card_no = 10'd100;
        push(EV_AUTH, cyc + 1, NT, 0);
        step();
        step();
        auth_done = 1'b1;
        auth_ok   = 1'b1;
        push(EV_SESS, cyc + 1, NT, 0);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({state, attempts_left, eject, auth_req, session_active, card_locked} != 9'd0) begin
            n_err++;
            $display("FAIL reset_mid_session: state=%0d att=%0d ej=%0b req=%0b sa=%0b lck=%0b, want all 0",
                     state, attempts_left, eject, auth_req, session_active, card_locked);
        end
        locked_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        run_card(37, 0, M_TXN);

        for (int c = 1; c <= 5; c++) run_card(c, NT, M_TXN);
        for (int c = 1; c <= 5; c++) run_card(c, 0, M_TXN);

        run_card(50, 0, M_TMO);
        run_card(51, 1, M_TMO);
        run_card(52, 0, M_KEEP);
        run_card(53, 0, M_CANOK);
        run_card(54, 1, M_CANOK);
        run_card(55, 2, M_CAN);

        for (int i = 0; i < 60; i++)
            run_card(int'($urandom_range(1, 8)), int'($urandom_range(0, NT)),
                     int'($urandom_range(0, 3)));

        repeat (5) step();
        n_vec++;
        if (exq.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: %0d expected events never seen, want 0", exq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
